// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Pipeline hazard controller for the 5-stage TSC core. It handles load-use
//   stalls (1..3 bubbles), flushes on an EX-stage branch mispredict
//   (predict-not-taken), freezes while instruction or data memory is waiting,
//   drains the pipe after HLT, and keeps saturating stall/flush counters.
//   The only registered state is the FSM, the stall and drain countdowns and
//   the two perf counters. Every pipeline control is combinational.
// Ports
//   clk, reset_n                  clock, async active-low reset
//   valid_id, inst_type_id        ID instruction valid / decoded type
//   rs1_id, rs2_id, use_rs*_id    ID source specifiers and their use flags
//   halt_id                       ID instruction is HLT
//   valid_ex, mem_read_ex, rd_ex  EX load detection
//   branch_ex, branch_taken_ex    EX branch resolution
//   mem_access_mem, d_mem_ready   data-memory handshake
//   i_mem_ready                   instruction-fetch handshake
//   pc_write, ir_write            PC and IF/ID write enables
//   bubblify, flush, flush_ex     NOP into ID/EX, kill IF/ID, kill ID/EX
//   freeze, halted                hold all pipe regs, core halted
//   stall_count, flush_count      saturating perf counters
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W      = 2,
  parameter int LOAD_USE_STALLS = 1,
  parameter int PIPE_DEPTH      = 5,
  parameter int CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  valid_id,
  input  logic [2:0]            inst_type_id,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  use_rs1_id,
  input  logic                  use_rs2_id,
  input  logic                  halt_id,
  input  logic                  valid_ex,
  input  logic                  mem_read_ex,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  branch_ex,
  input  logic                  branch_taken_ex,
  input  logic                  mem_access_mem,
  input  logic                  d_mem_ready,
  input  logic                  i_mem_ready,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  bubblify,
  output logic                  flush,
  output logic                  flush_ex,
  output logic                  freeze,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  // INSTTYPE_* encoding shared with the decoder; only JUMP matters here.
  localparam logic [2:0] INSTTYPE_JUMP = 3'd4;

  localparam int RW = 2;                       // holds up to LOAD_USE_STALLS-1 = 2
  localparam int DW = $clog2(PIPE_DEPTH) + 1;  // holds PIPE_DEPTH-2

  typedef enum logic [1:0] {RUN, LU_STALL, DRAIN, HALTED} state_t;

  state_t          state, state_nxt;
  logic [RW-1:0]   remaining, remaining_nxt;
  logic [DW-1:0]   drain_cnt, drain_nxt;

  logic lu_hazard, mispredict, data_wait;

  assign lu_hazard  = valid_ex & mem_read_ex & valid_id &
                      ((use_rs1_id & (rs1_id == rd_ex)) |
                       (use_rs2_id & (rs2_id == rd_ex)));
  assign mispredict = valid_ex & branch_ex & branch_taken_ex;
  assign data_wait  = mem_access_mem & ~d_mem_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      remaining <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    drain_nxt     = drain_cnt;
    pc_write      = 1'b1;
    ir_write      = 1'b1;
    bubblify      = 1'b0;
    flush         = 1'b0;
    flush_ex      = 1'b0;
    freeze        = 1'b0;
    halted        = 1'b0;

    if (state == HALTED) begin
      pc_write = 1'b0;
      ir_write = 1'b0;
      freeze   = 1'b1;
      halted   = 1'b1;
    end else if (data_wait) begin
      // Everything holds; the FSM and countdowns are frozen too.
      pc_write = 1'b0;
      ir_write = 1'b0;
      freeze   = 1'b1;
    end else if (mispredict) begin
      // Anything younger than the branch is wrong-path, including a pending
      // stall or a halt drain, so return straight to RUN.
      flush         = 1'b1;
      flush_ex      = 1'b1;
      state_nxt     = RUN;
      remaining_nxt = '0;
      drain_nxt     = '0;
    end else begin
      if (state == LU_STALL) begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        bubblify      = 1'b1;
        remaining_nxt = remaining - 1'b1;
        if (remaining <= RW'(1)) begin
          state_nxt     = RUN;
          remaining_nxt = '0;
        end
      end else if (state == DRAIN) begin
        pc_write  = 1'b0;
        flush     = 1'b1;
        drain_nxt = drain_cnt - 1'b1;
        if (drain_cnt <= DW'(1)) begin
          state_nxt = HALTED;
          drain_nxt = '0;
        end
      end else if (lu_hazard) begin
        pc_write = 1'b0;
        ir_write = 1'b0;
        bubblify = 1'b1;
        if (LOAD_USE_STALLS > 1) begin
          state_nxt     = LU_STALL;
          remaining_nxt = RW'(LOAD_USE_STALLS - 1);
        end
      end else if (valid_id & halt_id) begin
        pc_write  = 1'b0;
        flush     = 1'b1;
        state_nxt = DRAIN;
        drain_nxt = DW'(PIPE_DEPTH - 2);
      end else if (valid_id & (inst_type_id == INSTTYPE_JUMP)) begin
        flush = 1'b1;
      end
      // A fetch miss holds the PC and squashes whatever IF/ID would capture.
      if (!i_mem_ready) begin
        pc_write = 1'b0;
        flush    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write && (state != HALTED) && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if ((flush | flush_ex) && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;
  localparam int RA = 2;
  localparam int CW = 4;

  logic          clk, reset_n;
  logic          valid_id, halt_id, use_rs1_id, use_rs2_id;
  logic [2:0]    inst_type_id;
  logic [RA-1:0] rs1_id, rs2_id, rd_ex;
  logic          valid_ex, mem_read_ex, branch_ex, branch_taken_ex;
  logic          mem_access_mem, d_mem_ready, i_mem_ready;
  logic          pc_write, ir_write, bubblify, flush, flush_ex, freeze, halted;
  logic [CW-1:0] stall_count, flush_count;
  logic [6:0]    ctl;

  int total = 0;
  int bad   = 0;

  // {pc_write, ir_write, bubblify, flush, flush_ex, freeze, halted}
  assign ctl = {pc_write, ir_write, bubblify, flush, flush_ex, freeze, halted};

  hazard_ctrl_unit #(.REG_ADDR_W(RA), .LOAD_USE_STALLS(2), .PIPE_DEPTH(5), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .valid_id(valid_id), .inst_type_id(inst_type_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .halt_id(halt_id), .valid_ex(valid_ex), .mem_read_ex(mem_read_ex), .rd_ex(rd_ex),
    .branch_ex(branch_ex), .branch_taken_ex(branch_taken_ex),
    .mem_access_mem(mem_access_mem), .d_mem_ready(d_mem_ready), .i_mem_ready(i_mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .bubblify(bubblify), .flush(flush),
    .flush_ex(flush_ex), .freeze(freeze), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    valid_id = 0; inst_type_id = 3'd0; rs1_id = 0; rs2_id = 0;
    use_rs1_id = 0; use_rs2_id = 0; halt_id = 0;
    valid_ex = 0; mem_read_ex = 0; rd_ex = 0; branch_ex = 0; branch_taken_ex = 0;
    mem_access_mem = 0; d_mem_ready = 1; i_mem_ready = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); #1;
    total++; if (ctl !== 7'b1100000) begin bad++; $display("FAIL reset_ctl got=%b want=%b", ctl, 7'b1100000); end
    total++; if (stall_count !== 4'd0) begin bad++; $display("FAIL reset_stall got=%0d want=0", stall_count); end
    total++; if (flush_count !== 4'd0) begin bad++; $display("FAIL reset_flush got=%0d want=0", flush_count); end
  endtask

  task automatic test_load_use();
    do_reset();
    // Load r1 in EX, ID reads r1 on rs1 but does not use it: no hazard.
    @(negedge clk);
    valid_ex = 1; mem_read_ex = 1; rd_ex = 1; valid_id = 1; rs1_id = 1; use_rs1_id = 0;
    rs2_id = 2; use_rs2_id = 1; #1;
    total++; if (ctl !== 7'b1100000) begin bad++; $display("FAIL lu_unused got=%b want=%b", ctl, 7'b1100000); end
    // Same registers but EX is not a load: no hazard.
    @(negedge clk);
    mem_read_ex = 0; rs2_id = 1; #1;
    total++; if (ctl !== 7'b1100000) begin bad++; $display("FAIL lu_noload got=%b want=%b", ctl, 7'b1100000); end
    do_reset();
    // Real hazard on rs2: two bubbles.
    @(negedge clk);
    valid_ex = 1; mem_read_ex = 1; rd_ex = 1; valid_id = 1; rs1_id = 2; use_rs1_id = 1;
    rs2_id = 1; use_rs2_id = 1; #1;
    total++; if (ctl !== 7'b0010000) begin bad++; $display("FAIL lu_bubble1 got=%b want=%b", ctl, 7'b0010000); end
    @(negedge clk);
    valid_ex = 0; mem_read_ex = 0; #1;
    total++; if (ctl !== 7'b0010000) begin bad++; $display("FAIL lu_bubble2 got=%b want=%b", ctl, 7'b0010000); end
    @(negedge clk); #1;
    total++; if (ctl !== 7'b1100000) begin bad++; $display("FAIL lu_resume got=%b want=%b", ctl, 7'b1100000); end
    total++; if (stall_count !== 4'd2) begin bad++; $display("FAIL lu_stall_count got=%0d want=2", stall_count); end
  endtask

  task automatic test_mispredict();
    do_reset();
    @(negedge clk);
    valid_ex = 1; branch_ex = 1; branch_taken_ex = 0; #1;
    total++; if (ctl !== 7'b1100000) begin bad++; $display("FAIL br_nottaken got=%b want=%b", ctl, 7'b1100000); end
    @(negedge clk);
    branch_taken_ex = 1; #1;
    total++; if (ctl !== 7'b1101100) begin bad++; $display("FAIL br_taken got=%b want=%b", ctl, 7'b1101100); end
    @(negedge clk);
    idle(); #1;
    total++; if (flush_count !== 4'd1) begin bad++; $display("FAIL br_flush_count got=%0d want=1", flush_count); end
    total++; if (stall_count !== 4'd0) begin bad++; $display("FAIL br_stall_count got=%0d want=0", stall_count); end
  endtask

  task automatic test_mispredict_halt();
    do_reset();
    @(negedge clk);
    valid_ex = 1; branch_ex = 1; branch_taken_ex = 1; valid_id = 1; halt_id = 1; #1;
    total++; if (ctl !== 7'b1101100) begin bad++; $display("FAIL mph_flush got=%b want=%b", ctl, 7'b1101100); end
    @(negedge clk);
    idle(); #1;
    total++; if (ctl !== 7'b1100000) begin bad++; $display("FAIL mph_nodrain got=%b want=%b", ctl, 7'b1100000); end
  endtask

  task automatic test_halt();
    do_reset();
    @(negedge clk);
    valid_id = 1; halt_id = 1; #1;
    total++; if (ctl !== 7'b0101000) begin bad++; $display("FAIL halt_detect got=%b want=%b", ctl, 7'b0101000); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle(); #1;
      total++; if (ctl !== 7'b0101000) begin bad++; $display("FAIL halt_drain%0d got=%b want=%b", i, ctl, 7'b0101000); end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid_ex = 1; branch_ex = 1; branch_taken_ex = 1; i_mem_ready = 0; #1;
      total++; if (ctl !== 7'b0000011) begin bad++; $display("FAIL halt_hold%0d got=%b want=%b", i, ctl, 7'b0000011); end
    end
    total++; if (stall_count !== 4'd4) begin bad++; $display("FAIL halt_stall_count got=%0d want=4", stall_count); end
    total++; if (flush_count !== 4'd4) begin bad++; $display("FAIL halt_flush_count got=%0d want=4", flush_count); end
    @(negedge clk);
    idle(); reset_n = 0; #1;
    total++; if (ctl !== 7'b1100000) begin bad++; $display("FAIL halt_reset_ctl got=%b want=%b", ctl, 7'b1100000); end
    total++; if ({stall_count, flush_count} !== 8'h00) begin bad++; $display("FAIL halt_reset_cnt got=%h want=00", {stall_count, flush_count}); end
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_data_wait_stall();
    do_reset();
    @(negedge clk);
    valid_ex = 1; mem_read_ex = 1; rd_ex = 2; valid_id = 1; rs1_id = 2; use_rs1_id = 1; #1;
    total++; if (ctl !== 7'b0010000) begin bad++; $display("FAIL dw_bubble1 got=%b want=%b", ctl, 7'b0010000); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid_ex = 0; mem_read_ex = 0; mem_access_mem = 1; d_mem_ready = 0; #1;
      total++; if (ctl !== 7'b0000010) begin bad++; $display("FAIL dw_freeze%0d got=%b want=%b", i, ctl, 7'b0000010); end
    end
    @(negedge clk);
    mem_access_mem = 0; d_mem_ready = 1; #1;
    total++; if (ctl !== 7'b0010000) begin bad++; $display("FAIL dw_bubble2 got=%b want=%b", ctl, 7'b0010000); end
    @(negedge clk); #1;
    total++; if (ctl !== 7'b1100000) begin bad++; $display("FAIL dw_resume got=%b want=%b", ctl, 7'b1100000); end
    total++; if (stall_count !== 4'd6) begin bad++; $display("FAIL dw_stall_count got=%0d want=6", stall_count); end
    total++; if (flush_count !== 4'd0) begin bad++; $display("FAIL dw_flush_count got=%0d want=0", flush_count); end
  endtask

  task automatic test_jump_fetch();
    do_reset();
    @(negedge clk);
    valid_id = 1; inst_type_id = 3'd4; #1;
    total++; if (ctl !== 7'b1101000) begin bad++; $display("FAIL jump got=%b want=%b", ctl, 7'b1101000); end
    @(negedge clk);
    valid_id = 0; i_mem_ready = 0; #1;
    total++; if (ctl !== 7'b0101000) begin bad++; $display("FAIL fetch_miss got=%b want=%b", ctl, 7'b0101000); end
    @(negedge clk);
    valid_id = 1; #1;
    total++; if (ctl !== 7'b0101000) begin bad++; $display("FAIL jump_miss got=%b want=%b", ctl, 7'b0101000); end
    @(negedge clk);
    idle(); #1;
    total++; if (ctl !== 7'b1100000) begin bad++; $display("FAIL jf_resume got=%b want=%b", ctl, 7'b1100000); end
    total++; if (stall_count !== 4'd2) begin bad++; $display("FAIL jf_stall_count got=%0d want=2", stall_count); end
    total++; if (flush_count !== 4'd3) begin bad++; $display("FAIL jf_flush_count got=%0d want=3", flush_count); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      mem_access_mem = 1; d_mem_ready = 0;
    end
    @(negedge clk); #1;
    total++; if (stall_count !== 4'd15) begin bad++; $display("FAIL sat_stall_15 got=%0d want=15", stall_count); end
    @(negedge clk); #1;
    total++; if (stall_count !== 4'd15) begin bad++; $display("FAIL sat_stall_hold got=%0d want=15", stall_count); end
    total++; if (flush_count !== 4'd0) begin bad++; $display("FAIL sat_stall_noflush got=%0d want=0", flush_count); end
    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      i_mem_ready = 0;
    end
    #1;
    total++; if (flush_count !== 4'd15) begin bad++; $display("FAIL sat_flush_hold got=%0d want=15", flush_count); end
    total++; if (stall_count !== 4'd15) begin bad++; $display("FAIL sat_flush_stall got=%0d want=15", stall_count); end
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_mispredict();
    test_mispredict_halt();
    test_halt();
    test_data_wait_stall();
    test_jump_fetch();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised successor to the pipeline hazard unit: adds multi-cycle load-use stalling, EX-stage branch mispredict flush (predict-not-taken), instruction/data memory wait freezing, halt drain, and saturating stall/flush performance counters.
- Sits beside the control unit and drives the PC, IF/ID and ID/EX write/flush controls of the 5-stage TSC pipeline.
- Registered state (FSM, stall countdown, drain counter, perf counters); all pipeline controls are combinational from state and inputs.

Parameters:
REG_ADDR_W, 2, register-specifier width
LOAD_USE_STALLS, 1, bubbles per load-use hazard (legal 1..3; 2 when MEM->EX forwarding is absent)
PIPE_DEPTH, 5, number of pipeline stages; the drain length after halt is PIPE_DEPTH-2 cycles
CNT_W, 16, performance-counter width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
valid_id  in  1  ID holds a real instruction
inst_type_id  in  3  decoded type of the ID instruction (INSTTYPE_* encoding)
rs1_id, rs2_id  in  REG_ADDR_W  ID source registers
use_rs1_id, use_rs2_id  in  1  ID instruction reads rs1/rs2
halt_id  in  1  ID instruction is HLT
valid_ex  in  1  EX holds a real instruction
mem_read_ex  in  1  EX instruction is a load
rd_ex  in  REG_ADDR_W  EX destination register
branch_ex  in  1  EX instruction is a conditional branch
branch_taken_ex  in  1  branch resolved taken
mem_access_mem  in  1  valid load/store in MEM
d_mem_ready  in  1  data memory completes this cycle
i_mem_ready  in  1  instruction fetch completes this cycle
pc_write  out  1  PC update enable
ir_write  out  1  IF/ID write enable
bubblify  out  1  load a NOP into ID/EX
flush  out  1  invalidate IF/ID
flush_ex  out  1  invalidate ID/EX (mispredict)
freeze  out  1  hold every pipeline register
halted  out  1  core halted
stall_count  out  CNT_W  saturating count of stall cycles
flush_count  out  CNT_W  saturating count of flush cycles

Behaviour:
- FSM states: RUN, LU_STALL, DRAIN, HALTED. Reset sets RUN, both counters to 0, and remaining-stall and drain counters to 0. Outputs then follow the RUN defaults: pc_write=1, ir_write=1, all other controls 0, halted=0.
- Control priority, highest first, evaluated each cycle:
  1. HALTED: pc_write=ir_write=0, freeze=1, halted=1, all else 0. The FSM stays in HALTED until reset.
  2. Data wait (mem_access_mem & !d_mem_ready): freeze=1, pc_write=ir_write=0, bubblify=flush=flush_ex=0. No state or counter advances except stall_count.
  3. Mispredict (valid_ex & branch_ex & branch_taken_ex): pc_write=1, flush=1, flush_ex=1. This aborts LU_STALL or DRAIN and returns the FSM to RUN, because halt and stall are wrong-path.
  4. LU_STALL with remaining>0: pc_write=ir_write=0, bubblify=1; remaining decrements; the FSM goes to RUN when it reaches 0.
  5. Load-use detect in RUN (valid_ex & mem_read_ex & valid_id & ((use_rs1_id & rs1_id==rd_ex) | (use_rs2_id & rs2_id==rd_ex))): pc_write=ir_write=0, bubblify=1. If LOAD_USE_STALLS>1, go to LU_STALL with remaining=LOAD_USE_STALLS-1.
  6. Halt in RUN (valid_id & halt_id): pc_write=0, flush=1, go to DRAIN with count=PIPE_DEPTH-2. In DRAIN, pc_write=0 and flush=1 each cycle; the count decrements and the FSM goes to HALTED on the cycle it reaches 0.
  7. Jump (valid_id & inst_type_id==INSTTYPE_JUMP, RUN only): flush=1, pc_write=1.
  8. Fetch miss (!i_mem_ready): pc_write=0, flush=1. This is OR-combined with rules 4-7 on the flush and pc_write terms only.
- stall_count increments on any cycle with pc_write=0 outside HALTED. flush_count increments on any cycle with flush|flush_ex. Both saturate at all-ones and never wrap.
- Asserting reset_n low at any state, including mid-drain or mid-stall, returns to RUN on the next evaluation.

Test Plan:
- Load r1 in EX (rd_ex=1), ID reads rs2=1, LOAD_USE_STALLS=2 -> two consecutive cycles of bubblify=1, pc_write=0, ir_write=0, then RUN; stall_count=2.
- branch_ex=1, branch_taken_ex=1, valid_ex=1 -> flush=1, flush_ex=1, pc_write=1 in the same cycle; flush_count=1.
- Mispredict in EX while halt_id=1 in ID -> flush/flush_ex asserted, no DRAIN entry, halted stays 0.
- halt_id=1 with PIPE_DEPTH=5 -> 3 DRAIN cycles (pc_write=0, flush=1), then halted=1 and freeze=1 held indefinitely; reset_n low -> halted=0, counters 0.
- d_mem_ready=0 for 4 cycles during LU_STALL with remaining=1 -> freeze=1 for 4 cycles, remaining held at 1, one more bubble afterwards; stall_count +5.
- Preload stall_count=2^CNT_W-1 (CNT_W=4, 15 stalls) then one more stall -> stall_count stays at 15.
